// File: rtl/snoop_responder_if.sv
// snoop_responder_if: peer message, local line view, memory bus and ack signals of the snoop responder
interface snoop_responder_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16,
  parameter int IO_W   = 2,
  parameter int ST_W   = 2
);
  logic              havMsgFromCache;
  logic [ADDR_W-1:0] addrFromCache;
  logic              rmFromCache;
  logic              wmFromCache;
  logic              invFromCache;
  logic [ADDR_W-1:0] lineAddr;
  logic [ST_W-1:0]   lineState;
  logic [WORD_W-1:0] lineData;
  logic              memEn;
  logic              allowReadToCache;
  logic [ADDR_W-1:0] allowReadToCacheAddr;
  logic [IO_W-1:0]   rwToMem;
  logic [ADDR_W-1:0] addrToMem;
  logic [WORD_W-1:0] dataToMem;
  logic              stateWe;
  logic [ST_W-1:0]   stateNext;
  logic              busy;
  modport slave (
    input  havMsgFromCache, addrFromCache, rmFromCache, wmFromCache, invFromCache,
    input  lineAddr, lineState, lineData, memEn,
    output allowReadToCache, allowReadToCacheAddr, rwToMem, addrToMem, dataToMem,
    output stateWe, stateNext, busy
  );
  modport master (
    output havMsgFromCache, addrFromCache, rmFromCache, wmFromCache, invFromCache,
    output lineAddr, lineState, lineData, memEn,
    input  allowReadToCache, allowReadToCacheAddr, rwToMem, addrToMem, dataToMem,
    input  stateWe, stateNext, busy
  );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: answers peer rm/wm/inv messages against the local MSI line, writing back M data first
module snoop_responder #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16,
  parameter int IO_W   = 2,
  parameter int ST_W   = 2
) (
  input logic clk,
  input logic reset,
  snoop_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, WB, ACK} state_t;
  localparam logic [IO_W-1:0] IO_IDLE = IO_W'(0);
  localparam logic [IO_W-1:0] IO_WR   = IO_W'(2);
  localparam logic [ST_W-1:0] ST_I    = ST_W'(0);
  localparam logic [ST_W-1:0] ST_S    = ST_W'(1);
  localparam logic [ST_W-1:0] ST_M    = ST_W'(2);
  state_t            r_state;
  logic              r_hav;
  logic              r_rm;
  logic              r_inv;
  logic              r_hit;
  logic              r_busy;
  logic              r_ack;
  logic              r_we;
  logic [ST_W-1:0]   r_next;
  logic [IO_W-1:0]   r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_data;
  logic              w_rise;
  logic              w_hit;
  assign w_rise = bus.havMsgFromCache & ~r_hav;
  // a message with no flags set never hits, so it is acknowledged as a plain miss
  assign w_hit  = (r_rm | r_inv) && (bus.lineState != ST_I) && (bus.lineAddr == r_addr);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hav      <= 1'b0;
      r_rm       <= 1'b0;
      r_inv      <= 1'b0;
      r_hit      <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_we       <= 1'b0;
      r_next     <= ST_I;
      r_rw       <= IO_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_hav  <= bus.havMsgFromCache;
      r_ack  <= 1'b0;
      r_we   <= 1'b0;
      r_next <= ST_I;
      case (r_state)
        IDLE: begin
          r_busy <= w_rise;
          if (w_rise) begin
            r_addr  <= bus.addrFromCache;
            r_rm    <= bus.rmFromCache;
            r_inv   <= bus.wmFromCache | bus.invFromCache;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_hit <= w_hit;
          if (w_hit && bus.lineState == ST_M) begin
            r_rw       <= IO_WR;
            r_mem_addr <= bus.lineAddr;
            r_mem_data <= bus.lineData;
            r_state    <= WB;
          end else r_state <= ACK;
        end
        WB: begin
          if (bus.memEn) begin
            r_rw    <= IO_IDLE;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_ack   <= 1'b1;
          r_we    <= r_hit;
          r_next  <= r_hit ? (r_inv ? ST_I : ST_S) : ST_I;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.allowReadToCache     = r_ack;
  assign bus.allowReadToCacheAddr = r_addr;
  assign bus.rwToMem              = r_rw;
  assign bus.addrToMem            = r_mem_addr;
  assign bus.dataToMem            = r_mem_data;
  assign bus.stateWe              = r_we;
  assign bus.stateNext            = r_next;
  assign bus.busy                 = r_busy;
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: directed and random snoop transactions checked against a rule-level reference model
module tb_snoop_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  snoop_responder_if #(.ADDR_W(8), .WORD_W(16), .IO_W(2), .ST_W(2)) u_if ();
  snoop_responder #(.ADDR_W(8), .WORD_W(16), .IO_W(2), .ST_W(2)) u_dut (
    .clk(clk),
    .reset(rst),
    .bus(u_if)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic [7:0] la, input logic [1:0] ls, input logic [15:0] ld,
                     input logic [7:0] a, input bit rm, input bit wm, input bit inv,
                     input int d, input bit mem_in_check, input bit hold);
    bit hit, wb, seen;
    logic [1:0] nxt;
    int lat, k;
    hit = (rm | wm | inv) && ls != 2'd0 && la == a;
    wb  = hit && ls == 2'd2;
    nxt = hit ? ((wm | inv) ? 2'd0 : 2'd1) : 2'd0;
    lat = wb ? d + 4 : 3;
    u_if.lineAddr = la;
    u_if.lineState = ls;
    u_if.lineData = ld;
    u_if.addrFromCache = a;
    u_if.rmFromCache = rm;
    u_if.wmFromCache = wm;
    u_if.invFromCache = inv;
    u_if.havMsgFromCache = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      chk("busy", u_if.busy, 1);
      chk("rw", u_if.rwToMem, (wb && k >= 2 && k <= d + 2) ? 2 : 0);
      if (wb && k >= 2 && k <= d + 2) begin
        chk("wb_addr", u_if.addrToMem, la);
        chk("wb_data", u_if.dataToMem, ld);
      end
      if (u_if.allowReadToCache) seen = 1;
      u_if.memEn = (mem_in_check && k == 1) || (wb && k == d + 2);
    end
    chk("ack_seen", seen, 1);
    chk("latency", k, lat);
    chk("ack_addr", u_if.allowReadToCacheAddr, a);
    chk("state_we", u_if.stateWe, hit);
    chk("state_next", u_if.stateNext, nxt);
    u_if.memEn = 1'b0;
    if (!hold) u_if.havMsgFromCache = 1'b0;
    @(negedge clk);
    chk("ack_pulse_end", u_if.allowReadToCache, 0);
    chk("we_pulse_end", u_if.stateWe, 0);
    chk("busy_end", u_if.busy, 0);
    chk("ack_addr_hold", u_if.allowReadToCacheAddr, a);
  endtask
  initial begin
    int acks;
    u_if.havMsgFromCache = 1'b0;
    u_if.addrFromCache = '0;
    u_if.rmFromCache = 1'b0;
    u_if.wmFromCache = 1'b0;
    u_if.invFromCache = 1'b0;
    u_if.lineAddr = '0;
    u_if.lineState = '0;
    u_if.lineData = '0;
    u_if.memEn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", u_if.allowReadToCache, 0);
    chk("rst_rw", u_if.rwToMem, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_we", u_if.stateWe, 0);
    chk("rst_addr", u_if.allowReadToCacheAddr, 0);
    chk("rst_memaddr", u_if.addrToMem, 0);
    chk("rst_memdata", u_if.dataToMem, 0);
    // directed: S hit rm, M hit rm with 5-cycle memEn wait, M hit wm, S hit inv+rm
    txn(8'h00, 2'd1, 16'd0, 8'h00, 1, 0, 0, 0, 0, 0);
    txn(8'h00, 2'd2, 16'd3, 8'h00, 1, 0, 0, 5, 0, 0);
    txn(8'h00, 2'd2, 16'd4, 8'h00, 0, 1, 0, 0, 0, 0);
    txn(8'h00, 2'd1, 16'd9, 8'h00, 1, 0, 1, 0, 0, 0);
    txn(8'h05, 2'd2, 16'd7, 8'h00, 1, 0, 0, 0, 0, 0);
    txn(8'h00, 2'd0, 16'd7, 8'h00, 1, 0, 0, 0, 0, 0);
    txn(8'h00, 2'd2, 16'd7, 8'h00, 0, 0, 0, 0, 0, 0);
    txn(8'hff, 2'd2, 16'hbeef, 8'hff, 0, 0, 1, 2, 1, 0);
    txn(8'h00, 2'd1, 16'd0, 8'h00, 1, 0, 0, 0, 1, 0);
    // level held after ack: no second pulse, then a 1-cycle drop restarts
    txn(8'h00, 2'd1, 16'd0, 8'h00, 1, 0, 0, 0, 0, 1);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      acks += int'(u_if.allowReadToCache);
      acks += int'(u_if.busy);
    end
    chk("held_no_retrigger", acks, 0);
    u_if.havMsgFromCache = 1'b0;
    @(negedge clk);
    txn(8'h00, 2'd2, 16'd11, 8'h00, 1, 0, 0, 1, 0, 0);
    // asynchronous reset in the middle of a write-back
    u_if.lineAddr = 8'h10;
    u_if.lineState = 2'd2;
    u_if.lineData = 16'h1234;
    u_if.addrFromCache = 8'h10;
    u_if.rmFromCache = 1'b1;
    u_if.wmFromCache = 1'b0;
    u_if.invFromCache = 1'b0;
    u_if.havMsgFromCache = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_rw", u_if.rwToMem, 2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rw", u_if.rwToMem, 0);
    chk("async_rst_busy", u_if.busy, 0);
    chk("async_rst_addr", u_if.addrToMem, 0);
    u_if.havMsgFromCache = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(u_if.allowReadToCache) + int'(u_if.busy) + int'(u_if.rwToMem);
    end
    chk("post_rst_idle", acks, 0);
    txn(8'h10, 2'd2, 16'h1234, 8'h10, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      txn($urandom_range(0, 1) ? 8'h05 : 8'h00, 2'($urandom_range(0, 2)), 16'($urandom),
          $urandom_range(0, 1) ? 8'h05 : 8'h00, f[0], f[1], f[2],
          int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
